ex_mem_flag_stage: RTL and testbench

- Execute-to-memory pipeline register that sits directly downstream of the 16-bit ADD/NAND/SUB ALU.
- Captures the ALU result and its raw carry/zero outputs, and holds the architectural C and Z flag registers, updating them per instruction under flag_ctl.
- Resolves conditional-execute instructions (execute-if-C, execute-if-Z) by cancelling the register write and the flag update.
- Supports stall and flush from the hazard unit; 1-cycle latency.

---
 rtl/ex_mem_flag_stage.sv | 116 +++++++++++
 tb/tb_ex_mem_flag_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_flag_stage.sv
// Execute-to-memory register holding the ALU result and the architectural C/Z flags, with conditional-execute resolution.
// Latency: 1 cycle from ALU output to out_*; flags update on the same edge as the capture.
// Backpressure: stall holds every register and ignores the inputs; flush beats stall and leaves a bubble.
// Optional feature: define CANCEL_CNT_EN to add the saturating cancel_count output.
module ex_mem_flag_stage #(
    parameter int WIDTH   = 16,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic [1:0]         flag_ctl,
    input  logic [1:0]         cond,
    input  logic [RADDR_W-1:0] rd,
    input  logic               reg_wr,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_reg_wr,
    output logic               out_cancelled,
    output logic               carry_flag,
    output logic               zero_flag
`ifdef CANCEL_CNT_EN
    ,
    output logic [15:0]        cancel_count
`endif
);

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_IF_C   = 2'b01;
    localparam logic [1:0] COND_IF_Z   = 2'b10;

    logic capture;
    logic exec;
    logic upd_c;
    logic upd_z;

    // Condition reads the registered flags, so a dependent instruction right
    // behind a flag-setter sees the new value without a bubble.
    always_comb begin
        exec = 1'b0;
        case (cond)
            COND_ALWAYS: exec = 1'b1;
            COND_IF_C:   exec = carry_flag;
            COND_IF_Z:   exec = zero_flag;
            default:     exec = 1'b0;
        endcase
    end

    assign capture = in_valid & ~stall & ~flush;
    assign upd_c   = capture & exec & flag_ctl[1];
    assign upd_z   = capture & exec & flag_ctl[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_result    <= '0;
            out_rd        <= '0;
            out_reg_wr    <= 1'b0;
            out_cancelled <= 1'b0;
        end else if (flush) begin
            out_valid     <= 1'b0;
            out_reg_wr    <= 1'b0;
            out_cancelled <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                out_valid  <= 1'b1;
                out_result <= alu_result;
                out_rd     <= rd;
                if (exec) begin
                    out_reg_wr    <= reg_wr;
                    out_cancelled <= 1'b0;
                end else begin
                    out_reg_wr    <= 1'b0;
                    out_cancelled <= 1'b1;
                end
            end else begin
                out_valid     <= 1'b0;
                out_reg_wr    <= 1'b0;
                out_cancelled <= 1'b0;
            end
        end
    end

    // Only a qualified update lets alu_carry/alu_zero through, keeping an
    // undriven ALU flag output out of the architectural state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
        end else begin
            if (upd_c) begin
                carry_flag <= alu_carry;
            end
            if (upd_z) begin
                zero_flag <= alu_zero;
            end
        end
    end

`ifdef CANCEL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cancel_count <= 16'h0000;
        end else if (capture && !exec && (cancel_count != 16'hFFFF)) begin
            cancel_count <= cancel_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Scoreboarded bench for ex_mem_flag_stage: reference model predicts each edge, results compared 1 ns after it.
module tb_ex_mem_flag_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [15:0] alu_result;
    logic        alu_carry, alu_zero;
    logic [1:0]  flag_ctl, cond;
    logic [2:0]  rd;
    logic        reg_wr;
    logic        out_valid;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_reg_wr, out_cancelled, carry_flag, zero_flag;
`ifdef CANCEL_CNT_EN
    logic [15:0] cancel_count;
    logic [15:0] m_cnt;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        v;
        logic [15:0] res;
        logic [2:0]  rd;
        logic        wr;
        logic        canc;
        logic        c;
        logic        z;
    } exp_t;

    exp_t m;
    exp_t sb[$];

    always #5 clk = ~clk;

    ex_mem_flag_stage #(.WIDTH(16), .RADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .flag_ctl(flag_ctl), .cond(cond), .rd(rd), .reg_wr(reg_wr),
        .out_valid(out_valid), .out_result(out_result), .out_rd(out_rd),
        .out_reg_wr(out_reg_wr), .out_cancelled(out_cancelled),
        .carry_flag(carry_flag), .zero_flag(zero_flag)
`ifdef CANCEL_CNT_EN
        , .cancel_count(cancel_count)
`endif
    );

    function automatic exp_t observed();
        return {out_valid, out_result, out_rd, out_reg_wr, out_cancelled, carry_flag, zero_flag};
    endfunction

    task automatic model_reset();
        m = '0;
        sb.delete();
`ifdef CANCEL_CNT_EN
        m_cnt = 16'h0000;
`endif
    endtask

    // Drive one cycle, predict the edge, then compare against the popped expectation.
    task automatic step(input string tag, input logic iv, input logic st, input logic fl,
                        input logic [15:0] res, input logic c, input logic z,
                        input logic [1:0] fc, input logic [1:0] cd,
                        input logic [2:0] d, input logic wr);
        logic ok;
        exp_t e, o;
        in_valid = iv; stall = st; flush = fl; alu_result = res;
        alu_carry = c; alu_zero = z; flag_ctl = fc; cond = cd; rd = d; reg_wr = wr;
        ok = (cd == 2'b00) || (cd == 2'b01 && m.c) || (cd == 2'b10 && m.z);
        if (fl) begin
            m.v = 1'b0; m.wr = 1'b0; m.canc = 1'b0;
        end else if (!st) begin
            if (iv) begin
                m.v = 1'b1; m.res = res; m.rd = d;
                m.wr = ok ? wr : 1'b0;
                m.canc = !ok;
                if (ok && fc[1]) m.c = c;
                if (ok && fc[0]) m.z = z;
`ifdef CANCEL_CNT_EN
                if (!ok && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            end else begin
                m.v = 1'b0; m.wr = 1'b0; m.canc = 1'b0;
            end
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        o = observed();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, o, e);
        end
`ifdef CANCEL_CNT_EN
        total++;
        if (cancel_count !== m_cnt) begin
            bad++;
            $display("FAIL %s cancel_count: got %h want %h", tag, cancel_count, m_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        total++;
        if (observed() !== exp_t'(0)) begin
            bad++;
            $display("FAIL reset_state: got %h want 0", observed());
        end
    endtask

    task automatic test_add();
        step("add", 1, 0, 0, 16'h0000, 1, 1, 2'b11, 2'b00, 3'd3, 1);
        total++;
        if ({out_valid, out_result, out_rd, out_reg_wr, carry_flag, zero_flag} !== {1'b1, 16'h0000, 3'd3, 1'b1, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL add_explicit: got %b want 1_0000_3_1_1_1",
                     {out_valid, out_result, out_rd, out_reg_wr, carry_flag, zero_flag});
        end
    endtask

    task automatic test_cancel();
        // clear C with an unconditional update, then issue execute-if-C
        step("clear_c", 1, 0, 0, 16'h1234, 0, 0, 2'b10, 2'b00, 3'd1, 1);
        step("cond_c_cancel", 1, 0, 0, 16'h5555, 1, 0, 2'b11, 2'b01, 3'd2, 1);
        total++;
        if ({out_cancelled, out_reg_wr, carry_flag, zero_flag} !== 4'b1001) begin
            bad++;
            $display("FAIL cancel_explicit: got %b want 1001", {out_cancelled, out_reg_wr, carry_flag, zero_flag});
        end
        step("reserved_cond", 1, 0, 0, 16'h0001, 1, 1, 2'b11, 2'b11, 3'd4, 1);
    endtask

    task automatic test_back_to_back();
        step("b2b_set_c", 1, 0, 0, 16'h8000, 1, 0, 2'b11, 2'b00, 3'd5, 1);
        step("b2b_if_c", 1, 0, 0, 16'h0042, 0, 1, 2'b00, 2'b01, 3'd6, 1);
        total++;
        if ({out_reg_wr, out_cancelled} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_explicit: got %b want 10", {out_reg_wr, out_cancelled});
        end
        step("b2b_if_z_cancel", 1, 0, 0, 16'h0043, 0, 1, 2'b01, 2'b10, 3'd7, 1);
        step("idle", 0, 0, 0, 16'hDEAD, 0, 0, 2'b11, 2'b00, 3'd0, 1);
    endtask

    task automatic test_nand_x();
        step("nand_x_carry", 1, 0, 0, 16'hFFFF, 1'bx, 0, 2'b01, 2'b00, 3'd2, 1);
        total++;
        if ($isunknown(observed()) || zero_flag !== 1'b0 || carry_flag !== 1'b1) begin
            bad++;
            $display("FAIL nand_x: got c=%b z=%b want c=1 z=0", carry_flag, zero_flag);
        end
        step("x_both_masked", 1, 0, 0, 16'h0F0F, 1'bx, 1'bx, 2'b00, 2'b00, 3'd1, 0);
        step("x_cancelled", 1, 0, 0, 16'h0000, 1'bx, 1'bx, 2'b11, 2'b11, 3'd1, 1);
    endtask

    task automatic test_stall_flush();
        step("pre_stall", 1, 0, 0, 16'hA5A5, 0, 1, 2'b11, 2'b00, 3'd4, 1);
        for (int i = 0; i < 3; i++)
            step("stall_hold", 1, 1, 0, 16'h1000 + 16'(i), 1, 0, 2'b11, 2'b00, 3'(i), 1);
        step("flush_stall", 1, 1, 1, 16'h7777, 1, 0, 2'b11, 2'b00, 3'd7, 1);
        total++;
        if (out_valid !== 1'b0 || carry_flag !== 1'b0 || zero_flag !== 1'b1) begin
            bad++;
            $display("FAIL flush_explicit: got v=%b c=%b z=%b want v=0 c=0 z=1", out_valid, carry_flag, zero_flag);
        end
        step("flush_only", 1, 0, 1, 16'h3333, 1, 1, 2'b11, 2'b00, 3'd3, 1);
        step("stall_cancel_ignored", 1, 1, 0, 16'h0001, 1, 1, 2'b11, 2'b01, 3'd1, 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [1:0] fc;
            logic cx, zx;
            fc = 2'($urandom_range(0, 3));
            cx = fc[1] ? 1'($urandom_range(0, 1)) : 1'bx;
            zx = fc[0] ? 1'($urandom_range(0, 1)) : 1'bx;
            step("random", 1'($urandom_range(0, 3) != 0), $urandom_range(0, 5) == 0,
                 $urandom_range(0, 7) == 0, 16'($urandom), cx, zx, fc,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_async_reset();
        step("pre_reset_load", 1, 0, 0, 16'hBEEF, 1, 0, 2'b11, 2'b00, 3'd6, 1);
        step("stall_before_reset", 1, 1, 0, 16'h0000, 0, 0, 2'b11, 2'b00, 3'd0, 1);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (observed() !== exp_t'(0)) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", observed());
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        stall = 1'b0;
        step("after_reset", 1, 0, 0, 16'h00FF, 0, 1, 2'b01, 2'b10, 3'd2, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; stall = 0; flush = 0; alu_result = 0; alu_carry = 0;
        alu_zero = 0; flag_ctl = 0; cond = 0; rd = 0; reg_wr = 0;
        model_reset();
        #12;
        test_reset();
        rst_n = 1'b1;
        test_add();
        test_cancel();
        test_back_to_back();
        test_nand_x();
        test_stall_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
